// File: rtl/alu16_seq_pkg.sv
// Shared encodings for the 16-bit arithmetic sequencer and the 8-bit ALU it drives.
package alu16_seq_pkg;

  // Sequencer request op codes
  localparam logic [1:0] SEQ_ADD16 = 2'd0;
  localparam logic [1:0] SEQ_INC16 = 2'd1;
  localparam logic [1:0] SEQ_DEC16 = 2'd2;
  localparam logic [1:0] SEQ_ADDSP = 2'd3;

  // ALU opcodes used by the sequencer
  localparam logic [4:0] ALU_PASS0 = 5'd0;
  localparam logic [4:0] ALU_ADD   = 5'd1;
  localparam logic [4:0] ALU_ADC   = 5'd2;
  localparam logic [4:0] ALU_SUB   = 5'd3;
  localparam logic [4:0] ALU_SBC   = 5'd4;

  // ALU size selects
  localparam logic [1:0] ALU_SIZE_8    = 2'd0;
  localparam logic [1:0] ALU_SIZE_16   = 2'd1;
  localparam logic [1:0] ALU_SIZE_SPEC = 2'd2;

  // ZNHC flag bit positions
  localparam int unsigned FlagZ = 3;
  localparam int unsigned FlagN = 2;
  localparam int unsigned FlagH = 1;
  localparam int unsigned FlagC = 0;

  typedef struct packed {
    logic [4:0] op;
    logic [1:0] size;
  } alu_step_t;

  // ALU opcode and size for one byte step of a sequencer op
  function automatic alu_step_t step_cfg(logic [1:0] seq_op, logic high);
    alu_step_t cfg;
    logic      sub;
    sub      = (seq_op == SEQ_DEC16);
    cfg.op   = high ? (sub ? ALU_SBC : ALU_ADC) : (sub ? ALU_SUB : ALU_ADD);
    cfg.size = (seq_op == SEQ_ADDSP && !high) ? ALU_SIZE_SPEC : ALU_SIZE_16;
    return cfg;
  endfunction

  // Second-operand byte for one step; ADD SP,e sign-extends e into the high byte
  function automatic logic [7:0] b_byte(logic [1:0] seq_op, logic [15:0] b, logic high);
    logic [7:0] res;
    unique case (seq_op)
      SEQ_ADD16:            res = high ? b[15:8] : b[7:0];
      SEQ_INC16, SEQ_DEC16: res = high ? 8'h00 : 8'h01;
      default:              res = high ? {8{b[7]}} : b[7:0];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu16_seq.sv
// Sequences a 16-bit add/inc/dec/add-SP as two chained byte operations on the shared 8-bit ALU.
module alu16_seq
  import alu16_seq_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [3:0]  req_flags,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic [3:0]  resp_flags,
  output logic [7:0]  alu_data0,
  output logic [7:0]  alu_data1,
  output logic [4:0]  alu_op,
  output logic [3:0]  alu_flags,
  output logic [1:0]  alu_size,
  input  logic [7:0]  alu_result,
  input  logic [3:0]  alu_flags_res
);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  a_hi_q, a_hi_d;
  logic [7:0]  b_hi_q, b_hi_d;
  logic [3:0]  flags_q, flags_d;
  logic [1:0]  low_hc_q, low_hc_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [15:0] resp_data_q, resp_data_d;
  logic [3:0]  resp_flags_q, resp_flags_d;
  logic [7:0]  alu_data0_q, alu_data0_d;
  logic [7:0]  alu_data1_q, alu_data1_d;
  logic [4:0]  alu_op_q, alu_op_d;
  logic [3:0]  alu_flags_q, alu_flags_d;
  logic [1:0]  alu_size_q, alu_size_d;
  alu_step_t   step;

  // Z and N out of the ALU never reach the result flags
  logic unused_alu_zn;
  assign unused_alu_zn = ^alu_flags_res[3:2];

  // Next state; ALU port values are computed one cycle ahead so the ports come straight from flops
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_hi_d       = a_hi_q;
    b_hi_d       = b_hi_q;
    flags_d      = flags_q;
    low_hc_d     = low_hc_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_flags_d = resp_flags_q;
    alu_op_d     = ALU_PASS0;
    alu_size_d   = ALU_SIZE_8;
    alu_data0_d  = 8'h00;
    alu_data1_d  = 8'h00;
    alu_flags_d  = 4'h0;
    step         = '0;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          state_d     = StLow;
          op_d        = req_op;
          a_hi_d      = req_a[15:8];
          b_hi_d      = b_byte(req_op, req_b, 1'b1);
          flags_d     = req_flags;
          step        = step_cfg(req_op, 1'b0);
          alu_op_d    = step.op;
          alu_size_d  = step.size;
          alu_data1_d = req_a[7:0];
          alu_data0_d = b_byte(req_op, req_b, 1'b0);
          alu_flags_d = {req_flags[FlagZ], 3'b000};
        end
      end
      StLow: begin
        state_d           = StHigh;
        resp_data_d[7:0]  = alu_result;
        low_hc_d          = alu_flags_res[1:0];
        step              = step_cfg(op_q, 1'b1);
        alu_op_d          = step.op;
        alu_size_d        = step.size;
        alu_data1_d       = a_hi_q;
        alu_data0_d       = b_hi_q;
        // Carry/borrow of the low byte chains into the high byte
        alu_flags_d       = {flags_q[FlagZ], 2'b00, alu_flags_res[FlagC]};
      end
      StHigh: begin
        state_d           = StDone;
        resp_valid_d      = 1'b1;
        resp_data_d[15:8] = alu_result;
        unique case (op_q)
          SEQ_ADD16:            resp_flags_d = {flags_q[FlagZ], 1'b0, alu_flags_res[1:0]};
          SEQ_INC16, SEQ_DEC16: resp_flags_d = flags_q;
          default:              resp_flags_d = {2'b00, low_hc_q};
        endcase
      end
      StDone: begin
        if (resp_ready) begin
          state_d      = StIdle;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    req_ready_d = (state_d == StIdle);
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      op_q         <= SEQ_ADD16;
      a_hi_q       <= 8'h00;
      b_hi_q       <= 8'h00;
      flags_q      <= 4'h0;
      low_hc_q     <= 2'b00;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 16'h0000;
      resp_flags_q <= 4'h0;
      alu_op_q     <= ALU_PASS0;
      alu_size_q   <= ALU_SIZE_8;
      alu_data0_q  <= 8'h00;
      alu_data1_q  <= 8'h00;
      alu_flags_q  <= 4'h0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_hi_q       <= a_hi_d;
      b_hi_q       <= b_hi_d;
      flags_q      <= flags_d;
      low_hc_q     <= low_hc_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_flags_q <= resp_flags_d;
      alu_op_q     <= alu_op_d;
      alu_size_q   <= alu_size_d;
      alu_data0_q  <= alu_data0_d;
      alu_data1_q  <= alu_data1_d;
      alu_flags_q  <= alu_flags_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_flags = resp_flags_q;
  assign alu_op     = alu_op_q;
  assign alu_size   = alu_size_q;
  assign alu_data0  = alu_data0_q;
  assign alu_data1  = alu_data1_q;
  assign alu_flags  = alu_flags_q;

endmodule
